// File: rtl/oscillator_bank_if.sv
// Config and sample-stream port bundle for oscillator_bank.
// The master side drives config and out_ready; the slave side is the oscillator bank.
interface oscillator_bank_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CH_BITS    = 2,
  parameter int unsigned SHIFT_BITS = 3
);
  logic                         cfg_wr;
  logic [CH_BITS-1:0]           cfg_ch;
  logic                         cfg_en;
  logic [SHIFT_BITS-1:0]        cfg_shift;
  logic                         cfg_reload;
  logic signed [WIDTH-1:0]      cfg_amp;

  logic                         out_valid;
  logic                         out_ready;
  logic [CH_BITS-1:0]           out_ch;
  logic                         out_last;
  logic signed [WIDTH-1:0]      out_cos;
  logic signed [WIDTH-1:0]      out_sin;

  modport master (
    output cfg_wr, cfg_ch, cfg_en, cfg_shift, cfg_reload, cfg_amp, out_ready,
    input  out_valid, out_ch, out_last, out_cos, out_sin
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_en, cfg_shift, cfg_reload, cfg_amp, out_ready,
    output out_valid, out_ch, out_last, out_cos, out_sin
  );
endinterface

// File: rtl/oscillator_bank.sv
// Bank of sin/cos recurrence oscillators sharing one update datapath, visited round-robin,
// with per-channel enable/shift/reload config and a valid/ready sample output.
module oscillator_bank #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CH_BITS    = 2,
  parameter int unsigned SHIFT_BITS = 3,
  parameter int unsigned DEF_SHIFT  = 6,
  parameter int          DEF_AMP    = 115
) (
  input  logic               clk,
  input  logic               rst,
  oscillator_bank_if.slave   bus
);

  localparam int unsigned EXT_W = WIDTH + 1;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef logic signed [EXT_W-1:0] ext_t;

  localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(CHANNELS - 1);
  localparam ext_t               SAT_MAX  = EXT_W'((2 ** (WIDTH - 1)) - 1);
  localparam ext_t               SAT_MIN  = -SAT_MAX;
  localparam sample_t            RST_AMP  = WIDTH'(DEF_AMP);
  localparam logic [SHIFT_BITS-1:0] RST_SHIFT = SHIFT_BITS'(DEF_SHIFT);

  // Symmetric clamp: the most negative code is never produced.
  function automatic sample_t sat(input ext_t v);
    if (v > SAT_MAX) begin
      return WIDTH'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return WIDTH'(SAT_MIN);
    end else begin
      return WIDTH'(v);
    end
  endfunction

  // Per-channel state
  sample_t                 cos_q   [CHANNELS];
  sample_t                 cos_d   [CHANNELS];
  sample_t                 sin_q   [CHANNELS];
  sample_t                 sin_d   [CHANNELS];
  logic [SHIFT_BITS-1:0]   shift_q [CHANNELS];
  logic [SHIFT_BITS-1:0]   shift_d [CHANNELS];
  logic [CHANNELS-1:0]     en_q;
  logic [CHANNELS-1:0]     en_d;
  logic [CH_BITS-1:0]      ptr_q;
  logic [CH_BITS-1:0]      ptr_d;

  // Output register
  logic                    out_valid_q;
  logic                    out_valid_d;
  logic [CH_BITS-1:0]      out_ch_q;
  logic [CH_BITS-1:0]      out_ch_d;
  logic                    out_last_q;
  logic                    out_last_d;
  sample_t                 out_cos_q;
  sample_t                 out_cos_d;
  sample_t                 out_sin_q;
  sample_t                 out_sin_d;

  // Shared step datapath signals
  sample_t                 cur_cos_c;
  sample_t                 cur_sin_c;
  logic [SHIFT_BITS-1:0]   cur_shift_c;
  ext_t                    ext_cos_c;
  ext_t                    ext_sin_c;
  ext_t                    sin_sum_c;
  sample_t                 sin_n_c;
  ext_t                    ext_sin_n_c;
  ext_t                    cos_diff_c;
  sample_t                 cos_n_c;

  logic                    slot_free_c;
  logic                    cfg_hit_c;
  logic                    cancel_c;

  // One recurrence step for the channel under the pointer; cos uses the already-clamped sin.
  always_comb begin
    cur_cos_c   = cos_q[ptr_q];
    cur_sin_c   = sin_q[ptr_q];
    cur_shift_c = shift_q[ptr_q];
    ext_cos_c   = {cur_cos_c[WIDTH-1], cur_cos_c};
    ext_sin_c   = {cur_sin_c[WIDTH-1], cur_sin_c};
    sin_sum_c   = ext_sin_c + (ext_cos_c >>> cur_shift_c);
    sin_n_c     = sat(sin_sum_c);
    ext_sin_n_c = {sin_n_c[WIDTH-1], sin_n_c};
    cos_diff_c  = ext_cos_c - (ext_sin_n_c >>> cur_shift_c);
    cos_n_c     = sat(cos_diff_c);
  end

  // Scheduling, state update and config writes.
  always_comb begin
    ptr_d       = ptr_q;
    en_d        = en_q;
    shift_d     = shift_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_cos_d   = out_cos_q;
    out_sin_d   = out_sin_q;

    slot_free_c = !out_valid_q || bus.out_ready;
    cfg_hit_c   = bus.cfg_wr && (bus.cfg_ch <= LAST_CH);
    cancel_c    = cfg_hit_c && (bus.cfg_ch == ptr_q);

    if (slot_free_c) begin
      ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + CH_BITS'(1);
      if (en_q[ptr_q] && !cancel_c) begin
        cos_d[ptr_q] = cos_n_c;
        sin_d[ptr_q] = sin_n_c;
        out_valid_d  = 1'b1;
        out_ch_d     = ptr_q;
        out_last_d   = (ptr_q == LAST_CH);
        out_cos_d    = cos_n_c;
        out_sin_d    = sin_n_c;
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    // A write to the visited channel already cancelled its step, so this never races the update.
    if (cfg_hit_c) begin
      en_d[bus.cfg_ch]    = bus.cfg_en;
      shift_d[bus.cfg_ch] = bus.cfg_shift;
      if (bus.cfg_reload) begin
        cos_d[bus.cfg_ch] = bus.cfg_amp;
        sin_d[bus.cfg_ch] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cos_q[i]   <= RST_AMP;
        sin_q[i]   <= '0;
        shift_q[i] <= RST_SHIFT;
      end
      en_q        <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_cos_q   <= '0;
      out_sin_q   <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cos_q[i]   <= cos_d[i];
        sin_q[i]   <= sin_d[i];
        shift_q[i] <= shift_d[i];
      end
      en_q        <= en_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_cos_q   <= out_cos_d;
      out_sin_q   <= out_sin_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cos   = out_cos_q;
  assign bus.out_sin   = out_sin_q;

endmodule

// File: tb/tb_oscillator_bank.sv
// Directed bench for oscillator_bank: reset, single/multi channel stepping, backpressure,
// saturation, config collision and mid-stream reset, with hand-computed expected samples.
module tb_oscillator_bank;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned CHANNELS   = 4;
  localparam int unsigned CH_BITS    = 2;
  localparam int unsigned SHIFT_BITS = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  oscillator_bank_if #(.WIDTH(WIDTH), .CH_BITS(CH_BITS), .SHIFT_BITS(SHIFT_BITS)) bus ();

  oscillator_bank #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_BITS(CH_BITS), .SHIFT_BITS(SHIFT_BITS),
    .DEF_SHIFT(6), .DEF_AMP(115)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int v, input int ch, input int last,
                           input int cs, input int sn);
    chk({tag, ".valid"}, int'(bus.out_valid), v);
    chk({tag, ".ch"},    int'(bus.out_ch),    ch);
    chk({tag, ".last"},  int'(bus.out_last),  last);
    chk({tag, ".cos"},   int'(bus.out_cos),   cs);
    chk({tag, ".sin"},   int'(bus.out_sin),   sn);
  endtask

  task automatic set_cfg(input int ch, input logic en, input int shift, input logic reload,
                         input logic signed [WIDTH-1:0] amp);
    bus.cfg_wr     = 1'b1;
    bus.cfg_ch     = CH_BITS'(ch);
    bus.cfg_en     = en;
    bus.cfg_shift  = SHIFT_BITS'(shift);
    bus.cfg_reload = reload;
    bus.cfg_amp    = amp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, int'(bus.out_valid), 0);
    end
  endtask

  // After reset ptr=0, so writing ch0..3 in order collides with each visit: no samples.
  task automatic enable_all();
    for (int c = 0; c < 4; c++) begin
      set_cfg(c, 1'b1, 6, 1'b1, 8'sd115);
      tick();
      chk("en_all.novalid", int'(bus.out_valid), 0);
    end
    bus.cfg_wr = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.cfg_wr     = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_en     = 1'b0;
    bus.cfg_shift  = '0;
    bus.cfg_reload = 1'b0;
    bus.cfg_amp    = '0;
    bus.out_ready  = 1'b1;

    // 1: reset values, then idle with no channel enabled
    tick();
    tick();
    check_out("t1.reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle_check("t1.idle", 20);

    // 2: ch0 shift=1 from 115; write lands on ch0's visit and cancels it
    set_cfg(0, 1'b1, 1, 1'b1, 8'sd115);
    tick();
    bus.cfg_wr = 1'b0;
    chk("t2.cancel", int'(bus.out_valid), 0);
    idle_check("t2.gap1", 3);
    tick();
    check_out("t2.s1", 1, 0, 0, 87, 57);
    idle_check("t2.gap2", 3);
    tick();
    check_out("t2.s2", 1, 0, 0, 37, 100);

    // 3: all channels, continuous stream
    do_reset();
    enable_all();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_out("t3.stream", 1, i % 4, (i % 4 == 3) ? 1 : 0, 115, 1 + i / 4);
    end

    // 4: backpressure holds ch3 sample, then stream resumes at ch0 without loss
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t4.hold", 1, 3, 1, 115, 2);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("t4.resume", 1, i, (i == 3) ? 1 : 0, 115, 3);
    end

    // 5: saturation from -128 with shift 0
    do_reset();
    set_cfg(0, 1'b1, 0, 1'b1, 8'sh80);
    tick();
    bus.cfg_wr = 1'b0;
    idle_check("t5.gap1", 3);
    tick();
    check_out("t5.s1", 1, 0, 0, -1, -127);
    idle_check("t5.gap2", 3);
    tick();
    check_out("t5.s2", 1, 0, 0, 126, -127);

    // 6: reload ch2 on its own visit cancels that sample, next one steps from new amplitude
    do_reset();
    enable_all();
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out("t6.pre", 1, i % 4, (i % 4 == 3) ? 1 : 0, 115, 1 + i / 4);
    end
    set_cfg(2, 1'b1, 6, 1'b1, 8'sd100);
    tick();
    bus.cfg_wr = 1'b0;
    chk("t6.cancel", int'(bus.out_valid), 0);
    tick();
    check_out("t6.ch3", 1, 3, 1, 115, 2);
    tick();
    check_out("t6.ch0", 1, 0, 0, 115, 3);
    tick();
    check_out("t6.ch1", 1, 1, 0, 115, 3);
    tick();
    check_out("t6.ch2", 1, 2, 0, 100, 1);

    // mid-stream reset clears outputs and enables
    rst = 1'b1;
    tick();
    check_out("t6.rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle_check("t6.post", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
